// File: rtl/dpi_stream_sequencer_if.sv
// dpi_stream_sequencer_if
//   Groups the signals of the stream sequencer into one bundle:
//   - Packet input: in_data, in_valid, in_sop, in_eop (to the sequencer);
//     in_ready (from the sequencer).
//   - Enable-table config: cfg_we, cfg_addr, cfg_data, and flush.
//   - Matcher-bank control: load_state, stream_id, new_stream_id, enable,
//     char_in, char_in_vld, eop.
//   - Counters: pkt_count, drop_count.
//   Modports:
//   - master: the side that feeds packets and config.
//   - slave: the sequencer itself.
interface dpi_stream_sequencer_if #(
  parameter int NUM_REGEX = 8
);
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_sop;
  logic                 in_eop;
  logic                 in_ready;
  logic                 cfg_we;
  logic [5:0]           cfg_addr;
  logic [NUM_REGEX-1:0] cfg_data;
  logic                 flush;
  logic                 load_state;
  logic [5:0]           stream_id;
  logic                 new_stream_id;
  logic [NUM_REGEX-1:0] enable;
  logic [7:0]           char_in;
  logic                 char_in_vld;
  logic                 eop;
  logic [15:0]          pkt_count;
  logic [15:0]          drop_count;

  modport master (
    output in_data, in_valid, in_sop, in_eop, cfg_we, cfg_addr, cfg_data, flush,
    input  in_ready, load_state, stream_id, new_stream_id, enable,
           char_in, char_in_vld, eop, pkt_count, drop_count
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, cfg_we, cfg_addr, cfg_data, flush,
    output in_ready, load_state, stream_id, new_stream_id, enable,
           char_in, char_in_vld, eop, pkt_count, drop_count
  );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer
//   Front end for the per-regex matcher bank.
//   - It takes a byte-serial packet stream whose first four bytes are a
//     32-bit flow key.
//   - It maps the key to a 6-bit stream ID through a 64-entry fully
//     associative table.
//   - It then drives the matcher control sequence: load_state, the payload
//     characters, and a delayed eop.
//   - The per-stream enable mask comes from a table that the CPU can write.
//   Ports:
//   - clk: clock.
//   - rst_n: synchronous reset, active low.
//   - io_seq: slave side of dpi_stream_sequencer_if. It carries the packet
//     input and handshake, the config/flush inputs, the matcher control
//     outputs, and the counters.
//   Parameters:
//   - NUM_REGEX: width of the enable mask.
//   - DEFAULT_EN: mask given to a freshly allocated ID.
//   - EOP_DELAY: idle cycles between the last char and eop. Minimum 2.
module dpi_stream_sequencer #(
  parameter int                   NUM_REGEX  = 8,
  parameter logic [NUM_REGEX-1:0] DEFAULT_EN = '1,
  parameter int                   EOP_DELAY  = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  dpi_stream_sequencer_if.slave io_seq
);

  typedef enum logic [2:0] {
    IDLE, KEY, LOOKUP, LOAD, SETTLE, PAYLOAD, DRAIN, EOP
  } state_t;

  state_t               r_state;
  logic [31:0]          r_key;
  logic [1:0]           r_keyCnt;
  logic                 r_pendEop;
  logic [7:0]           r_drainCnt;
  logic [63:0]          r_valid;
  logic [5:0]           r_victim;
  logic                 r_flushPend;
  logic                 r_inReady;
  logic                 r_loadState;
  logic [5:0]           r_streamId;
  logic                 r_newId;
  logic [NUM_REGEX-1:0] r_enable;
  logic [7:0]           r_charIn;
  logic                 r_charVld;
  logic                 r_eop;
  logic [15:0]          r_pktCount;
  logic [15:0]          r_dropCount;

  logic [31:0]          r_keyTable [64];
  logic [NUM_REGEX-1:0] r_enTable  [64];

  logic       w_accept;
  logic       w_drop;
  logic       w_hit;
  logic [5:0] w_hitIdx;
  logic [5:0] w_freeIdx;
  logic       w_freeExists;
  logic [5:0] w_allocIdx;

  assign w_accept = io_seq.in_valid & r_inReady;

  // A runt is a packet that ends before its 4th key byte. A stray byte is
  // one that arrives in IDLE without sop. Both count as drops.
  assign w_drop = w_accept &&
                  ((r_state == IDLE && (!io_seq.in_sop || io_seq.in_eop)) ||
                   (r_state == KEY && io_seq.in_eop && r_keyCnt != 2'd3));

  // Compare the key against all entries in parallel. The loop runs from the
  // top index down, so the lowest matching index and the lowest free index
  // are the ones left at the end.
  always_comb begin
    w_hit     = 1'b0;
    w_hitIdx  = 6'd0;
    w_freeIdx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (r_valid[i] && r_keyTable[i] == r_key) begin
        w_hit    = 1'b1;
        w_hitIdx = 6'(i);
      end
      if (!r_valid[i]) begin
        w_freeIdx = 6'(i);
      end
    end
  end

  assign w_freeExists = ~&r_valid;
  assign w_allocIdx   = w_freeExists ? w_freeIdx : r_victim;

  // The key and enable arrays are not reset; the valid bits decide whether
  // an entry is live. An allocation's DEFAULT_EN is written after the cfg
  // write, so it wins when both hit the same index in the same cycle.
  always_ff @(posedge clk) begin
    if (io_seq.cfg_we) begin
      r_enTable[io_seq.cfg_addr] <= io_seq.cfg_data;
    end
    if (rst_n && r_state == LOOKUP && !w_hit) begin
      r_enTable[w_allocIdx]  <= DEFAULT_EN;
      r_keyTable[w_allocIdx] <= r_key;
    end
  end

  // Main sequencer.
  // - Every output is registered. Each one is set on the transition into
  //   the state where it must be visible.
  // - in_ready is 1 exactly in IDLE, KEY and PAYLOAD. It is 0 during the
  //   first cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_key       <= 32'd0;
      r_keyCnt    <= 2'd0;
      r_pendEop   <= 1'b0;
      r_drainCnt  <= 8'd0;
      r_valid     <= 64'd0;
      r_victim    <= 6'd0;
      r_flushPend <= 1'b0;
      r_inReady   <= 1'b0;
      r_loadState <= 1'b0;
      r_streamId  <= 6'd0;
      r_newId     <= 1'b0;
      r_enable    <= '0;
      r_charIn    <= 8'd0;
      r_charVld   <= 1'b0;
      r_eop       <= 1'b0;
      r_pktCount  <= 16'd0;
      r_dropCount <= 16'd0;
    end else begin
      r_loadState <= 1'b0;
      r_charVld   <= 1'b0;
      r_eop       <= 1'b0;

      case (r_state)
        IDLE: begin
          r_inReady <= 1'b1;
          if (w_accept && io_seq.in_sop && !io_seq.in_eop) begin
            r_key    <= {r_key[23:0], io_seq.in_data};
            r_keyCnt <= 2'd1;
            r_state  <= KEY;
          end
        end

        KEY: begin
          if (w_accept) begin
            r_key <= {r_key[23:0], io_seq.in_data};
            if (r_keyCnt == 2'd3) begin
              r_pendEop <= io_seq.in_eop;
              r_inReady <= 1'b0;
              r_state   <= LOOKUP;
            end else if (io_seq.in_eop) begin
              r_state <= IDLE;
            end else begin
              r_keyCnt <= r_keyCnt + 2'd1;
            end
          end
        end

        LOOKUP: begin
          r_loadState <= 1'b1;
          r_state     <= LOAD;
          if (w_hit) begin
            r_streamId <= w_hitIdx;
            r_newId    <= 1'b0;
            r_enable   <= r_enTable[w_hitIdx];
          end else begin
            r_streamId          <= w_allocIdx;
            r_newId             <= 1'b1;
            r_enable            <= DEFAULT_EN;
            r_valid[w_allocIdx] <= 1'b1;
            if (!w_freeExists) begin
              r_victim <= r_victim + 6'd1;
            end
          end
        end

        LOAD: begin
          r_state <= SETTLE;
        end

        // A key-only packet skips PAYLOAD. It has no trailing char cycle,
        // so it drains one cycle less.
        SETTLE: begin
          if (r_pendEop) begin
            r_drainCnt <= 8'(EOP_DELAY - 1);
            r_state    <= DRAIN;
          end else begin
            r_inReady <= 1'b1;
            r_state   <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (w_accept) begin
            r_charIn  <= io_seq.in_data;
            r_charVld <= 1'b1;
            if (io_seq.in_eop) begin
              r_inReady  <= 1'b0;
              r_drainCnt <= 8'(EOP_DELAY);
              r_state    <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (r_drainCnt == 8'd0) begin
            r_eop   <= 1'b1;
            r_state <= EOP;
          end else begin
            r_drainCnt <= r_drainCnt - 8'd1;
          end
        end

        EOP: begin
          r_pktCount <= r_pktCount + 16'd1;
          r_pendEop  <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase

      if (w_drop && r_dropCount != 16'hFFFF) begin
        r_dropCount <= r_dropCount + 16'd1;
      end

      // Flush only acts while IDLE, so a packet in flight keeps its
      // entry. A flush seen in any other state is held until IDLE.
      if (r_state == IDLE && (io_seq.flush || r_flushPend)) begin
        r_valid     <= 64'd0;
        r_victim    <= 6'd0;
        r_flushPend <= 1'b0;
      end else if (io_seq.flush) begin
        r_flushPend <= 1'b1;
      end
    end
  end

  assign io_seq.in_ready      = r_inReady;
  assign io_seq.load_state    = r_loadState;
  assign io_seq.stream_id     = r_streamId;
  assign io_seq.new_stream_id = r_newId;
  assign io_seq.enable        = r_enable;
  assign io_seq.char_in       = r_charIn;
  assign io_seq.char_in_vld   = r_charVld;
  assign io_seq.eop           = r_eop;
  assign io_seq.pkt_count     = r_pktCount;
  assign io_seq.drop_count    = r_dropCount;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb_dpi_stream_sequencer
//   Scoreboard bench for dpi_stream_sequencer.
//   - Each packet sent pushes its expected load, char and eop events, each
//     with the cycle in which it should appear.
//   - A monitor records the events the DUT actually produces.
//   - Each scenario task then compares the two queues.
module tb_dpi_stream_sequencer;
  localparam int NUM_REGEX = 8;
  localparam int EOP_DELAY = 2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [31:0] cyc;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cycleCnt = 32'd0;
  int          compared = 0;
  int          failed = 0;

  evt_t expQ[$];
  evt_t obsQ[$];

  logic [31:0] mKey [64];
  logic        mValid [64];
  logic [7:0]  mEn [64];
  int          mVictim;
  int          mPkt;
  int          mDrop;
  logic        mFlushPend;

  dpi_stream_sequencer_if #(.NUM_REGEX(NUM_REGEX)) seqIf ();

  dpi_stream_sequencer #(
    .NUM_REGEX (NUM_REGEX),
    .DEFAULT_EN(8'hFF),
    .EOP_DELAY (EOP_DELAY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_seq(seqIf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 32'd1;

  function automatic evt_t mkEvt(input logic [1:0] k, input logic [31:0] d, input logic [31:0] c);
    evt_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    return e;
  endfunction

  // Record what the DUT emits, sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    if (seqIf.load_state === 1'b1)
      obsQ.push_back(mkEvt(2'd0, 32'({seqIf.new_stream_id, seqIf.stream_id, seqIf.enable}), cycleCnt));
    if (seqIf.char_in_vld === 1'b1)
      obsQ.push_back(mkEvt(2'd1, 32'(seqIf.char_in), cycleCnt));
    if (seqIf.eop === 1'b1)
      obsQ.push_back(mkEvt(2'd2, 32'd0, cycleCnt));
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
    mVictim    = 0;
    mPkt       = 0;
    mDrop      = 0;
    mFlushPend = 1'b0;
  endtask

  // Reference table: exact-match search first, then first free slot, then
  // round-robin victim.
  task automatic modelLookup(input logic [31:0] key, output logic [5:0] id, output logic isNew);
    id    = 6'd0;
    isNew = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (mValid[i] && mKey[i] == key) begin
        id    = 6'(i);
        isNew = 1'b0;
        return;
      end
    end
    for (int i = 0; i < 64; i++) begin
      if (!mValid[i]) begin
        id = 6'(i);
        mValid[i] = 1'b1;
        mKey[i]   = key;
        mEn[i]    = 8'hFF;
        return;
      end
    end
    id = 6'(mVictim);
    mKey[mVictim] = key;
    mEn[mVictim]  = 8'hFF;
    mVictim = (mVictim + 1) % 64;
  endtask

  task automatic sendByte(input logic [7:0] d, input logic sop, input logic eop, output logic [31:0] acc);
    int waitCnt = 0;
    seqIf.in_data  = d;
    seqIf.in_valid = 1'b1;
    seqIf.in_sop   = sop;
    seqIf.in_eop   = eop;
    while (seqIf.in_ready !== 1'b1 && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    acc = cycleCnt;
    if (waitCnt >= 50) begin
      compared++;
      failed++;
      $display("[TB] FAIL in_ready_wait: in_ready=%b after 50 cycles, required 1", seqIf.in_ready);
    end
    @(posedge clk); #1;
    seqIf.in_valid = 1'b0;
    seqIf.in_sop   = 1'b0;
    seqIf.in_eop   = 1'b0;
  endtask

  // Send one packet and push the events the reference expects from it.
  // flushAt < 0 means no flush is pulsed during the packet.
  task automatic sendPacket(input logic [31:0] key, input int nPay, input logic [7:0] seed, input int flushAt);
    logic [31:0] t;
    logic [31:0] a;
    logic [5:0]  id;
    logic        isNew;
    logic [7:0]  kb;
    logic [7:0]  pb;
    for (int b = 0; b < 4; b++) begin
      kb = key[31-8*b -: 8];
      sendByte(kb, b == 0, (b == 3) && (nPay == 0), t);
    end
    modelLookup(key, id, isNew);
    expQ.push_back(mkEvt(2'd0, 32'({isNew, id, mEn[id]}), t + 32'd2));
    a = t;
    for (int i = 0; i < nPay; i++) begin
      pb = seed + 8'(i);
      if (i == flushAt) seqIf.flush = 1'b1;
      sendByte(pb, 1'b0, i == nPay - 1, a);
      seqIf.flush = 1'b0;
      if (i == flushAt) mFlushPend = 1'b1;
      expQ.push_back(mkEvt(2'd1, 32'(pb), a + 32'd1));
    end
    if (nPay == 0)
      expQ.push_back(mkEvt(2'd2, 32'd0, t + 32'd4 + 32'(EOP_DELAY)));
    else
      expQ.push_back(mkEvt(2'd2, 32'd0, a + 32'd2 + 32'(EOP_DELAY)));
    mPkt++;
    if (mFlushPend) begin
      for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
      mVictim    = 0;
      mFlushPend = 1'b0;
    end
  endtask

  task automatic cfgWrite(input logic [5:0] addr, input logic [7:0] data);
    seqIf.cfg_we   = 1'b1;
    seqIf.cfg_addr = addr;
    seqIf.cfg_data = data;
    @(posedge clk); #1;
    seqIf.cfg_we = 1'b0;
    mEn[addr] = data;
  endtask

  task automatic waitForEvents();
    int waitCnt = 0;
    while (obsQ.size() < expQ.size() && waitCnt < 200) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    modelReset();
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({seqIf.in_ready, seqIf.load_state, seqIf.new_stream_id, seqIf.char_in_vld, seqIf.eop} !== 5'b0) begin
      failed++;
      $display("[TB] FAIL reset_ctrl: got rdy/load/new/vld/eop=%b, required 00000",
               {seqIf.in_ready, seqIf.load_state, seqIf.new_stream_id, seqIf.char_in_vld, seqIf.eop});
    end
    compared++;
    if ({seqIf.char_in, seqIf.stream_id, seqIf.enable, seqIf.pkt_count, seqIf.drop_count} !== '0) begin
      failed++;
      $display("[TB] FAIL reset_data: got char=%h id=%0d en=%h pkt=%0d drop=%0d, required all 0",
               seqIf.char_in, seqIf.stream_id, seqIf.enable, seqIf.pkt_count, seqIf.drop_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (seqIf.in_ready !== 1'b1) begin
      failed++;
      $display("[TB] FAIL reset_ready: got in_ready=%b, required 1", seqIf.in_ready);
    end
    modelReset();
  endtask

  task automatic test_first_packet();
    evt_t e, o;
    sendPacket(32'hDEADBEEF, 3, 8'h11, -1);
    waitForEvents();
    compared++;
    if (obsQ.size() !== expQ.size()) begin
      failed++;
      $display("[TB] FAIL first_pkt_count: got %0d events, required %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      compared++;
      if (o !== e) begin
        failed++;
        $display("[TB] FAIL first_pkt_evt: got kind=%0d data=%h cyc=%0d, required kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    expQ.delete(); obsQ.delete();
    compared++;
    if (seqIf.pkt_count !== 16'(mPkt)) begin
      failed++;
      $display("[TB] FAIL first_pkt_pktcount: got %0d, required %0d", seqIf.pkt_count, mPkt);
    end
  endtask

  task automatic test_cfg_hit();
    evt_t e, o;
    cfgWrite(6'd0, 8'h05);
    sendPacket(32'hDEADBEEF, 2, 8'h40, -1);
    waitForEvents();
    compared++;
    if (obsQ.size() !== expQ.size()) begin
      failed++;
      $display("[TB] FAIL cfg_hit_count: got %0d events, required %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      compared++;
      if (o !== e) begin
        failed++;
        $display("[TB] FAIL cfg_hit_evt: got kind=%0d data=%h cyc=%0d, required kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_runts();
    logic [31:0] acc;
    sendByte(8'h12, 1'b1, 1'b0, acc);
    sendByte(8'h34, 1'b0, 1'b1, acc);
    mDrop++;
    compared++;
    if (seqIf.drop_count !== 16'(mDrop)) begin
      failed++;
      $display("[TB] FAIL runt2_drop: got %0d, required %0d", seqIf.drop_count, mDrop);
    end
    sendByte(8'h55, 1'b0, 1'b0, acc);
    mDrop++;
    compared++;
    if (seqIf.drop_count !== 16'(mDrop)) begin
      failed++;
      $display("[TB] FAIL stray_drop: got %0d, required %0d", seqIf.drop_count, mDrop);
    end
    sendByte(8'h66, 1'b1, 1'b1, acc);
    sendByte(8'h01, 1'b1, 1'b0, acc);
    sendByte(8'h02, 1'b0, 1'b0, acc);
    sendByte(8'h03, 1'b0, 1'b1, acc);
    mDrop += 2;
    waitForEvents();
    compared++;
    if (seqIf.drop_count !== 16'(mDrop)) begin
      failed++;
      $display("[TB] FAIL runt_1_3_drop: got %0d, required %0d", seqIf.drop_count, mDrop);
    end
    compared++;
    if (obsQ.size() !== 0) begin
      failed++;
      $display("[TB] FAIL runt_no_activity: got %0d matcher events, required 0", obsQ.size());
    end
    obsQ.delete();
  endtask

  task automatic test_key_only();
    evt_t e, o;
    sendPacket(32'h01020304, 0, 8'h00, -1);
    waitForEvents();
    compared++;
    if (obsQ.size() !== expQ.size()) begin
      failed++;
      $display("[TB] FAIL key_only_count: got %0d events, required %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      compared++;
      if (o !== e) begin
        failed++;
        $display("[TB] FAIL key_only_evt: got kind=%0d data=%h cyc=%0d, required kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    expQ.delete(); obsQ.delete();
    compared++;
    if (seqIf.pkt_count !== 16'(mPkt)) begin
      failed++;
      $display("[TB] FAIL key_only_pktcount: got %0d, required %0d", seqIf.pkt_count, mPkt);
    end
  endtask

  // Sixty-four keys fill the table in order. The next two new keys evict
  // IDs 0 and 1. Resending the very first key then misses again.
  task automatic test_eviction();
    evt_t e, o;
    resetDut();
    for (int i = 0; i < 66; i++) sendPacket(32'hA0000000 + 32'(i), 0, 8'h00, -1);
    sendPacket(32'hA0000000, 1, 8'h77, -1);
    waitForEvents();
    compared++;
    if (obsQ.size() !== expQ.size()) begin
      failed++;
      $display("[TB] FAIL evict_count: got %0d events, required %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      compared++;
      if (o !== e) begin
        failed++;
        $display("[TB] FAIL evict_evt: got kind=%0d data=%h cyc=%0d, required kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    expQ.delete(); obsQ.delete();
    compared++;
    if (seqIf.pkt_count !== 16'(mPkt)) begin
      failed++;
      $display("[TB] FAIL evict_pktcount: got %0d, required %0d", seqIf.pkt_count, mPkt);
    end
  endtask

  task automatic test_mid_reset();
    evt_t e, o;
    logic [31:0] t, a;
    logic [5:0]  id;
    logic        isNew;
    logic [7:0]  kb;
    for (int b = 0; b < 4; b++) begin
      kb = 8'hC0 + 8'(b);
      sendByte(kb, b == 0, 1'b0, t);
    end
    modelLookup(32'hC0C1C2C3, id, isNew);
    expQ.push_back(mkEvt(2'd0, 32'({isNew, id, mEn[id]}), t + 32'd2));
    for (int i = 0; i < 2; i++) begin
      sendByte(8'h90 + 8'(i), 1'b0, 1'b0, a);
      expQ.push_back(mkEvt(2'd1, 32'(8'h90 + 8'(i)), a + 32'd1));
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({seqIf.in_ready, seqIf.load_state, seqIf.new_stream_id, seqIf.char_in_vld, seqIf.eop} !== 5'b0) begin
      failed++;
      $display("[TB] FAIL midreset_ctrl: got rdy/load/new/vld/eop=%b, required 00000",
               {seqIf.in_ready, seqIf.load_state, seqIf.new_stream_id, seqIf.char_in_vld, seqIf.eop});
    end
    compared++;
    if ({seqIf.char_in, seqIf.stream_id, seqIf.enable, seqIf.pkt_count, seqIf.drop_count} !== '0) begin
      failed++;
      $display("[TB] FAIL midreset_data: got char=%h id=%0d en=%h pkt=%0d drop=%0d, required all 0",
               seqIf.char_in, seqIf.stream_id, seqIf.enable, seqIf.pkt_count, seqIf.drop_count);
    end
    rst_n = 1'b1;
    modelReset();
    repeat (10) @(posedge clk);
    #1;
    waitForEvents();
    compared++;
    if (obsQ.size() !== expQ.size()) begin
      failed++;
      $display("[TB] FAIL midreset_count: got %0d events (eop after reset?), required %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      compared++;
      if (o !== e) begin
        failed++;
        $display("[TB] FAIL midreset_evt: got kind=%0d data=%h cyc=%0d, required kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  // A flush pulsed mid-payload must not disturb the packet in flight. A
  // key known before the flush is then new again.
  task automatic test_flush();
    evt_t e, o;
    sendPacket(32'h11223344, 2, 8'h20, -1);
    sendPacket(32'h55667788, 4, 8'h30, 1);
    sendPacket(32'h11223344, 1, 8'h50, -1);
    waitForEvents();
    compared++;
    if (obsQ.size() !== expQ.size()) begin
      failed++;
      $display("[TB] FAIL flush_count: got %0d events, required %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      compared++;
      if (o !== e) begin
        failed++;
        $display("[TB] FAIL flush_evt: got kind=%0d data=%h cyc=%0d, required kind=%0d data=%h cyc=%0d",
                 o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  initial begin
    seqIf.in_data  = 8'd0;
    seqIf.in_valid = 1'b0;
    seqIf.in_sop   = 1'b0;
    seqIf.in_eop   = 1'b0;
    seqIf.cfg_we   = 1'b0;
    seqIf.cfg_addr = 6'd0;
    seqIf.cfg_data = 8'd0;
    seqIf.flush    = 1'b0;
    modelReset();

    test_reset();
    test_first_packet();
    test_cfg_hit();
    test_runts();
    test_key_only();
    test_eviction();
    test_mid_reset();
    test_flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
